// File: rtl/lc3_mem_arb_if.sv
// Bus bundle between the LC-3 fetch/memory stages, the arbiter and the shared memory port.
// The arbiter connects through the slave modport; stage/memory models use master.
interface lc3_mem_arb_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_valid;
  logic [15:0] mem_rdata;

  logic        m_en;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_valid, mem_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_valid, mem_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/lc3_mem_arb.sv
// Single-port memory arbiter for LC-3 fetch (IF) and memory (MEM) stages; MEM has priority.
// Optional IF anti-starvation guard enabled by defining LC3_ARB_STARVE_GUARD_EN.
module lc3_mem_arb #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  lc3_mem_arb_if.slave  bus_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  state_e      state_q,     state_d;
  owner_e      owner_q,     owner_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        we_q,        we_d;
  logic [15:0] addr_q,      addr_d;
  logic [15:0] wdata_q,     wdata_d;
  logic [15:0] if_rdata_q,  if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;

  logic        if_gnt_q,    if_gnt_d;
  logic        mem_gnt_q,   mem_gnt_d;
  logic        if_valid_q,  if_valid_d;
  logic        mem_valid_q, mem_valid_d;
  logic        m_en_q,      m_en_d;
  logic        m_we_q,      m_we_d;

  logic        any_req_s;
  logic        pick_mem_s;
  logic        if_forced_s;

`ifdef LC3_ARB_STARVE_GUARD_EN
  logic [1:0]  starve_q, starve_d;

  // After three MEM grants in a row that left IF waiting, IF wins the next tie.
  assign if_forced_s = bus_io.if_req && (starve_q == 2'd3);

  // Starvation counter: advance on MEM grants that bypass a waiting IF, clear otherwise.
  always_comb begin
    starve_d = starve_q;
    if ((state_q == IDLE) && any_req_s) begin
      if (pick_mem_s && bus_io.if_req) begin
        starve_d = starve_q + 2'd1;
      end else begin
        starve_d = 2'd0;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign if_forced_s = 1'b0;
`endif

  assign any_req_s  = bus_io.if_req || bus_io.mem_req;
  assign pick_mem_s = bus_io.mem_req && !if_forced_s;

  // State register and transaction datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      mem_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state and datapath capture logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
          if (pick_mem_s) begin
            owner_d = OWN_MEM;
            we_d    = bus_io.mem_we;
            addr_d  = bus_io.mem_addr;
            wdata_d = bus_io.mem_wdata;
          end else begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = bus_io.if_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Treat 0 as done too so a corrupted count can never lock the port.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          if (we_q) begin
            state_d = RESP;
          end else if (owner_q == OWN_MEM) begin
            mem_rdata_d = bus_io.m_rdata;
          end else begin
            if_rdata_d = bus_io.m_rdata;
          end
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so every strobe comes straight from a flop.
  always_comb begin
    if_gnt_d    = (state_q == IDLE) && (state_d == BUSY) && (owner_d == OWN_IF);
    mem_gnt_d   = (state_q == IDLE) && (state_d == BUSY) && (owner_d == OWN_MEM);
    if_valid_d  = (state_d == RESP) && (owner_d == OWN_IF);
    mem_valid_d = (state_d == RESP) && (owner_d == OWN_MEM);
    m_en_d      = (state_d == BUSY);
    m_we_d      = (state_d == BUSY) && we_d;
  end

  // Registered handshake and memory-control strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_gnt_q    <= 1'b0;
      mem_gnt_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
    end else begin
      if_gnt_q    <= if_gnt_d;
      mem_gnt_q   <= mem_gnt_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      m_en_q      <= m_en_d;
      m_we_q      <= m_we_d;
    end
  end

  assign bus_io.if_gnt    = if_gnt_q;
  assign bus_io.if_valid  = if_valid_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.mem_gnt   = mem_gnt_q;
  assign bus_io.mem_valid = mem_valid_q;
  assign bus_io.mem_rdata = mem_rdata_q;
  assign bus_io.m_en      = m_en_q;
  assign bus_io.m_we      = m_we_q;
  assign bus_io.m_addr    = addr_q;
  assign bus_io.m_wdata   = wdata_q;

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Directed bench for lc3_mem_arb: instance A uses WAIT_CYCLES=2, instance B uses WAIT_CYCLES=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lc3_mem_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lc3_mem_arb_if a ();
  lc3_mem_arb_if b ();

  lc3_mem_arb #(.WAIT_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(a));
  lc3_mem_arb #(.WAIT_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int         ng;
    logic [5:0] got;
    logic [5:0] exp_order;

    a.if_req = 1'b0; a.if_addr = 16'h0000; a.mem_req = 1'b0; a.mem_we = 1'b0;
    a.mem_addr = 16'h0000; a.mem_wdata = 16'h0000; a.m_rdata = 16'h0000;
    b.if_req = 1'b0; b.if_addr = 16'h0000; b.mem_req = 1'b0; b.mem_we = 1'b0;
    b.mem_addr = 16'h0000; b.mem_wdata = 16'h0000; b.m_rdata = 16'h0000;

    // Reset state
    #1;
    chk("rst_if_gnt",    {15'd0, a.if_gnt},    16'h0000);
    chk("rst_mem_gnt",   {15'd0, a.mem_gnt},   16'h0000);
    chk("rst_if_valid",  {15'd0, a.if_valid},  16'h0000);
    chk("rst_mem_valid", {15'd0, a.mem_valid}, 16'h0000);
    chk("rst_m_en",      {15'd0, a.m_en},      16'h0000);
    chk("rst_m_addr",    a.m_addr,             16'h0000);
    chk("rst_if_rdata",  a.if_rdata,           16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Single IF fetch, WAIT_CYCLES=2
    a.if_req = 1'b1; a.if_addr = 16'h3000; a.m_rdata = 16'h1234;
    tick();
    chk("if1_gnt_c1",   {15'd0, a.if_gnt},   16'h0001);
    chk("if1_m_en_c1",  {15'd0, a.m_en},     16'h0001);
    chk("if1_m_addr_c1", a.m_addr,           16'h3000);
    chk("if1_m_we_c1",  {15'd0, a.m_we},     16'h0000);
    chk("if1_valid_c1", {15'd0, a.if_valid}, 16'h0000);
    a.if_req = 1'b0; a.if_addr = 16'hFFFF;
    tick();
    chk("if1_gnt_c2",   {15'd0, a.if_gnt},   16'h0000);
    chk("if1_m_en_c2",  {15'd0, a.m_en},     16'h0001);
    chk("if1_m_addr_c2", a.m_addr,           16'h3000);
    tick();
    chk("if1_valid_c3", {15'd0, a.if_valid}, 16'h0001);
    chk("if1_rdata_c3", a.if_rdata,          16'h1234);
    chk("if1_m_en_c3",  {15'd0, a.m_en},     16'h0000);
    tick();
    chk("if1_valid_c4", {15'd0, a.if_valid}, 16'h0000);
    chk("if1_m_addr_hold", a.m_addr,         16'h3000);

    // Simultaneous requests: MEM load first, IF after one idle cycle
    a.if_req = 1'b1; a.if_addr = 16'h3002;
    a.mem_req = 1'b1; a.mem_we = 1'b0; a.mem_addr = 16'h4000; a.m_rdata = 16'h5678;
    tick();
    chk("both_mem_gnt", {15'd0, a.mem_gnt}, 16'h0001);
    chk("both_if_gnt0", {15'd0, a.if_gnt},  16'h0000);
    chk("both_m_addr",  a.m_addr,           16'h4000);
    a.mem_req = 1'b0;
    tick();
    tick();
    chk("both_mem_valid", {15'd0, a.mem_valid}, 16'h0001);
    chk("both_if_valid0", {15'd0, a.if_valid},  16'h0000);
    chk("both_mem_rdata", a.mem_rdata,          16'h5678);
    chk("both_if_rdata_hold", a.if_rdata,       16'h1234);
    tick();
    chk("both_bubble_gnt", {15'd0, a.if_gnt | a.mem_gnt}, 16'h0000);
    tick();
    chk("both_if_gnt", {15'd0, a.if_gnt}, 16'h0001);
    chk("both_if_addr", a.m_addr,         16'h3002);
    a.if_req = 1'b0; a.m_rdata = 16'h9ABC;
    tick();
    tick();
    chk("both_if_valid", {15'd0, a.if_valid}, 16'h0001);
    chk("both_if_rdata", a.if_rdata,          16'h9ABC);
    chk("both_mem_rdata_hold", a.mem_rdata,   16'h5678);
    tick();

    // Store: write strobes during BUSY, MEM_RDATA untouched
    a.mem_req = 1'b1; a.mem_we = 1'b1; a.mem_addr = 16'h4010; a.mem_wdata = 16'hBEEF;
    a.m_rdata = 16'h1111;
    tick();
    chk("st_gnt",     {15'd0, a.mem_gnt}, 16'h0001);
    chk("st_m_we_c1", {15'd0, a.m_we},    16'h0001);
    chk("st_m_addr",  a.m_addr,           16'h4010);
    chk("st_wdata_c1", a.m_wdata,         16'hBEEF);
    a.mem_req = 1'b0; a.mem_we = 1'b0; a.mem_wdata = 16'h0000;
    tick();
    chk("st_m_we_c2", {15'd0, a.m_we},    16'h0001);
    chk("st_wdata_c2", a.m_wdata,         16'hBEEF);
    tick();
    chk("st_valid",   {15'd0, a.mem_valid}, 16'h0001);
    chk("st_m_we_c3", {15'd0, a.m_we},      16'h0000);
    chk("st_rdata_hold", a.mem_rdata,       16'h5678);
    tick();

    // Request pulse that never meets a rising edge is ignored
    a.mem_req = 1'b1;
    #2;
    a.mem_req = 1'b0;
    tick();
    chk("drop_no_gnt",  {15'd0, a.mem_gnt}, 16'h0000);
    chk("drop_no_m_en", {15'd0, a.m_en},    16'h0000);

    // Reset in the second BUSY cycle aborts the fetch
    a.if_req = 1'b1; a.if_addr = 16'h3100; a.m_rdata = 16'h2222;
    tick();
    chk("rb_gnt", {15'd0, a.if_gnt}, 16'h0001);
    a.if_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rb_m_en",     {15'd0, a.m_en},   16'h0000);
    chk("rb_m_addr",   a.m_addr,          16'h0000);
    chk("rb_m_wdata",  a.m_wdata,         16'h0000);
    chk("rb_if_rdata", a.if_rdata,        16'h0000);
    chk("rb_mem_rdata", a.mem_rdata,      16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_no_valid", {15'd0, a.if_valid | a.mem_valid}, 16'h0000);
      chk("rb_no_m_en",  {15'd0, a.m_en},                  16'h0000);
    end
    a.mem_req = 1'b1; a.mem_we = 1'b0; a.mem_addr = 16'h4020; a.m_rdata = 16'h3333;
    tick();
    chk("rb_next_gnt", {15'd0, a.mem_gnt}, 16'h0001);
    a.mem_req = 1'b0;
    tick();
    tick();
    chk("rb_next_valid", {15'd0, a.mem_valid}, 16'h0001);
    chk("rb_next_rdata", a.mem_rdata,          16'h3333);
    tick();

    // Both requests held high: grant order
`ifdef LC3_ARB_STARVE_GUARD_EN
    exp_order = 6'b110111;
`else
    exp_order = 6'b111111;
`endif
    ng  = 0;
    got = 6'b000000;
    a.if_req = 1'b1; a.if_addr = 16'h3200; a.mem_req = 1'b1; a.mem_addr = 16'h4200;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("hold_one_gnt", {15'd0, a.if_gnt & a.mem_gnt}, 16'h0000);
      if (a.if_gnt || a.mem_gnt) begin
        if (ng < 6) got[ng] = a.mem_gnt;
        ng++;
      end
    end
    chk("hold_ngrants", 16'(ng),       16'd6);
    chk("hold_order",   {10'd0, got},  {10'd0, exp_order});
    a.if_req = 1'b0; a.mem_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // WAIT_CYCLES=1, back-to-back IF fetches
    b.if_req = 1'b1; b.if_addr = 16'h5000; b.m_rdata = 16'h4444;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("w1_gnt",   {15'd0, b.if_gnt},   {15'd0, (i % 3) == 0});
      chk("w1_valid", {15'd0, b.if_valid}, {15'd0, (i % 3) == 1});
    end
    b.if_req = 1'b0;
    chk("w1_rdata", b.if_rdata, 16'h4444);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arb.md
LC3_MEM_ARB -- requirements
Module: lc3_mem_arb

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory read/write latency in cycles (legal 1..15).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 IF_REQ  input  1  fetch-stage read request; held high until IF_GNT.
REQ-005 IF_ADDR  input  16  fetch address.
REQ-006 IF_GNT  output  1  one-cycle pulse: fetch request accepted.
REQ-007 IF_VALID  output  1  one-cycle pulse: IF_RDATA valid.
REQ-008 IF_RDATA  output  16  fetched word.
REQ-009 MEM_REQ  input  1  memory-stage request; held high until MEM_GNT.
REQ-010 MEM_WE  input  1  1 = store, 0 = load.
REQ-011 MEM_ADDR  input  16  load/store address.
REQ-012 MEM_WDATA  input  16  store data.
REQ-013 MEM_GNT  output  1  one-cycle pulse: memory-stage request accepted.
REQ-014 MEM_VALID  output  1  one-cycle pulse: load data valid or store complete.
REQ-015 MEM_RDATA  output  16  loaded word.
REQ-016 M_EN, M_WE  output  1 each  shared memory port enable and write enable.
REQ-017 M_ADDR, M_WDATA  output  16 each  shared memory port address and write data.
REQ-018 M_RDATA  input  16  shared memory port read data.

Function
REQ-019 FSM states IDLE, BUSY, RESP; owner register (IF or MEM); wait counter 4 bits.
REQ-020 IDLE: at an edge with any REQ high, SHALL select owner, latch addr/we/wdata, load counter with WAIT_CYCLES, go BUSY; no REQ -> stay IDLE.
REQ-021 Selection: MEM has priority over IF when both requesting (subject to REQ-034).
REQ-022 Owner's GNT SHALL be high only in the first BUSY cycle.
REQ-023 BUSY: M_EN=1, M_ADDR/M_WE/M_WDATA from latched values, held stable; counter decrements each edge; at the edge where counter==1 capture M_RDATA into owner's RDATA (loads only) and go RESP.
REQ-024 RESP: owner's VALID=1 for exactly one cycle, M_EN=0; next edge -> IDLE.
REQ-025 Latency: REQ sampled at edge E0 -> GNT in cycle after E0 -> VALID in cycle after E(WAIT_CYCLES); one idle bubble before next grant.
REQ-026 Outside BUSY, M_EN=M_WE=0; M_ADDR/M_WDATA hold last latched values.
REQ-027 Stores: MEM_RDATA unchanged; MEM_VALID still pulses as completion.
REQ-028 IF_RDATA/MEM_RDATA hold value until next completed load by same owner.
REQ-029 REQ inputs ignored in BUSY and RESP; a REQ dropped before being sampled in IDLE produces no transaction.
REQ-030 Addr/data inputs may change after GNT without affecting the transaction.
REQ-031 At most one GNT and one VALID high in any cycle.

Reset
REQ-032 RST_N low SHALL immediately force state IDLE, counter 0, owner IF, starvation counter 0, all GNT/VALID/M_EN/M_WE 0, all 16-bit outputs 0x0000.
REQ-033 Reset during BUSY/RESP aborts the transaction; no VALID issued for it after release; first edge after release behaves as IDLE.

Configuration
REQ-034 LC3_ARB_STARVE_GUARD_EN defined: 2-bit counter counts consecutive MEM grants made while IF_REQ high; when it equals 3 and both request, IF wins; counter clears on any IF grant or any MEM grant with IF_REQ low.
REQ-035 LC3_ARB_STARVE_GUARD_EN undefined: strict MEM priority; no starvation counter present.

Verification
REQ-036 WAIT_CYCLES=2, IF_REQ with IF_ADDR=0x3000, M_RDATA=0x1234 -> IF_GNT in cycle 1, M_ADDR=0x3000 with M_EN=1 cycles 1-2, IF_VALID cycle 3, IF_RDATA=0x1234.
REQ-037 IF_REQ and MEM_REQ (load 0x4000) same edge -> MEM_GNT first, MEM_VALID, then IF_GNT after one idle cycle.
REQ-038 MEM store addr 0x4010 data 0xBEEF -> M_WE=1, M_WDATA=0xBEEF during BUSY, MEM_VALID pulse, MEM_RDATA unchanged.
REQ-039 Both REQ held high continuously, guard enabled -> grant order MEM,MEM,MEM,IF,MEM...; guard disabled -> IF never granted.
REQ-040 RST_N low in second BUSY cycle -> all outputs 0 immediately, no VALID after release, next REQ served normally.
REQ-041 WAIT_CYCLES=1 back-to-back IF requests -> GNT every 3 cycles, VALID one cycle after each GNT.
